// File: rtl/control_unit_if.sv
// Instruction-ROM, data-memory and register-file control bundle driven by control_unit.
// The master side is the controller; the slave side is the ROM/datapath.
interface control_unit_if;
    logic [15:0] I_data;
    logic [6:0]  I_addr;
    logic        I_rd;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;

    modport master (
        input  I_data,
        output I_addr, I_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, Alu_s0
    );

    modport slave (
        output I_data,
        input  I_addr, I_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, Alu_s0
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FSM controller: fetches from a synchronous ROM and sequences LOAD/STORE/ADD/SUB/HALT.
// Optional CTRL_SINGLE_STEP_EN adds a step input that gates each FETCH.
module control_unit (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                  step,
`endif
    control_unit_if.master        bus,
    output logic [3:0]            state_out,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_NOOP   = 4'd9
    } state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_pc;
    // Opcode is consumed into the state at DECODE; only the operand field is kept.
    logic [11:0] r_ir;
    logic        w_go;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_pc    <= 7'd0;
            r_ir    <= 12'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_INIT: begin
                    r_pc <= 7'd0;
                    r_ir <= 12'd0;
                end
                S_FETCH:  if (w_go) r_pc <= r_pc + 7'd1;
                S_DECODE: r_ir <= bus.I_data[11:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = w_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.I_data[15:12])
                    4'b0001: w_next = S_STORE;
                    4'b0010: w_next = S_LOAD_A;
                    4'b0011: w_next = S_ADD;
                    4'b0100: w_next = S_SUB;
                    4'b0101: w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_NOOP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        bus.I_addr     = 7'd0;
        bus.I_rd       = 1'b0;
        bus.D_Addr     = 8'd0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'd0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'd0;
        bus.RF_Rb_addr = 4'd0;
        bus.Alu_s0     = 3'b000;
        case (r_state)
            S_FETCH: begin
                if (w_go) begin
                    bus.I_rd   = 1'b1;
                    bus.I_addr = r_pc;
                end
            end
            S_LOAD_A: bus.D_Addr = r_ir[11:4];
            S_LOAD_B: begin
                bus.D_Addr    = r_ir[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = r_ir[3:0];
                bus.RF_W_en   = 1'b1;
            end
            S_STORE: begin
                bus.D_Addr     = r_ir[11:4];
                bus.RF_Ra_addr = r_ir[3:0];
                bus.D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = r_ir[11:8];
                bus.RF_Rb_addr = r_ir[7:4];
                bus.RF_W_addr  = r_ir[3:0];
                bus.RF_W_en    = 1'b1;
                bus.Alu_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
    end

    assign state_out = r_state;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes per-cycle expected snapshots,
// a negedge monitor pops and compares them against the live outputs.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       hlt;
        logic       ird;
        logic [6:0] ia;
        logic [7:0] da;
        logic       dwr;
        logic       rfs;
        logic [3:0] wa;
        logic       wen;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  state_out;
    logic        halted;
    logic [15:0] rom [0:127];
    snap_t       exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (1'b1),
`endif
        .bus       (bus),
        .state_out (state_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    initial bus.I_data = 16'h0000;
    always @(posedge clk) if (bus.I_rd) bus.I_data <= rom[bus.I_addr];

    function automatic snap_t cur();
        snap_t s;
        s.st  = state_out;      s.hlt = halted;
        s.ird = bus.I_rd;       s.ia  = bus.I_addr;
        s.da  = bus.D_Addr;     s.dwr = bus.D_wr;
        s.rfs = bus.RF_s;       s.wa  = bus.RF_W_addr;
        s.wen = bus.RF_W_en;    s.ra  = bus.RF_Ra_addr;
        s.rb  = bus.RF_Rb_addr; s.alu = bus.Alu_s0;
        return s;
    endfunction

    always @(negedge clk) begin
        snap_t g, e;
        if (rst_n && exp_q.size() > 0) begin
            g = cur();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL snap st=%0d: got %h exp %h", e.st, g, e);
            end
            n_tests++;
            if (bus.D_wr && bus.RF_W_en) begin
                n_fail++;
                $display("FAIL wr_excl: got D_wr=1 RF_W_en=1 exp not both");
            end
        end
    end

    function automatic snap_t blank(input logic [3:0] st);
        snap_t s = '0;
        s.st = st;
        return s;
    endfunction

    task automatic p_init();  exp_q.push_back(blank(4'd0)); endtask
    task automatic p_dec();   exp_q.push_back(blank(4'd2)); endtask
    task automatic p_noop();  exp_q.push_back(blank(4'd9)); endtask
    task automatic p_halt();
        snap_t s = blank(4'd8); s.hlt = 1'b1; exp_q.push_back(s);
    endtask
    task automatic p_fetch(input logic [6:0] pc);
        snap_t s = blank(4'd1); s.ird = 1'b1; s.ia = pc; exp_q.push_back(s);
    endtask
    task automatic p_lda(input logic [7:0] da);
        snap_t s = blank(4'd3); s.da = da; exp_q.push_back(s);
    endtask
    task automatic p_ldb(input logic [7:0] da, input logic [3:0] w);
        snap_t s = blank(4'd4);
        s.da = da; s.rfs = 1'b1; s.wa = w; s.wen = 1'b1; exp_q.push_back(s);
    endtask
    task automatic p_alu(input logic [3:0] st, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] w, input logic [2:0] alu);
        snap_t s = blank(st);
        s.ra = ra; s.rb = rb; s.wa = w; s.wen = 1'b1; s.alu = alu; exp_q.push_back(s);
    endtask
    task automatic p_store(input logic [7:0] da, input logic [3:0] ra);
        snap_t s = blank(4'd5);
        s.da = da; s.ra = ra; s.dwr = 1'b1; exp_q.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_state"}, {28'd0, state_out}, 32'd0);
        chk({nm, "_outs"}, {16'd0, cur()}, 32'd0);
    endtask

    task automatic go_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk_zero("rst");
    endtask

    task automatic release_rst();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending exp 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        clear_rom();
        #3 chk_zero("por");

        // Program A: LOAD, ADD, SUB, STORE, undefined opcode, NOOP, HALT
        rom[0] = 16'h2053; rom[1] = 16'h3124; rom[2] = 16'h4124;
        rom[3] = 16'h1A76; rom[4] = 16'hF000; rom[5] = 16'h0000;
        rom[6] = 16'h5000;
        p_init();
        p_fetch(7'd0); p_dec(); p_lda(8'h05); p_ldb(8'h05, 4'd3);
        p_fetch(7'd1); p_dec(); p_alu(4'd6, 4'd1, 4'd2, 4'd4, 3'b001);
        p_fetch(7'd2); p_dec(); p_alu(4'd7, 4'd1, 4'd2, 4'd4, 3'b010);
        p_fetch(7'd3); p_dec(); p_store(8'hA7, 4'd6);
        p_fetch(7'd4); p_dec(); p_noop();
        p_fetch(7'd5); p_dec(); p_noop();
        p_fetch(7'd6); p_dec();
        for (int i = 0; i < 4; i++) p_halt();
        release_rst();
        drain("progA");

        // Program B: NOOP / undefined opcodes everywhere, PC wraps past 127
        go_reset();
        for (int i = 0; i < 128; i++) rom[i] = (i % 3 == 0) ? 16'hF000 : 16'h0000;
        p_init();
        for (int k = 0; k < 130; k++) begin
            p_fetch(7'(k % 128)); p_dec(); p_noop();
        end
        release_rst();
        drain("wrap");

        // Program C: HALT at address 2 persists
        go_reset();
        clear_rom();
        rom[2] = 16'h5000;
        p_init();
        p_fetch(7'd0); p_dec(); p_noop();
        p_fetch(7'd1); p_dec(); p_noop();
        p_fetch(7'd2); p_dec();
        for (int i = 0; i < 20; i++) p_halt();
        release_rst();
        drain("halt");
        repeat (10) @(posedge clk);
        #1 chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_state", {28'd0, state_out}, 32'd8);

        // Program D: reset asserted mid-LOAD_B, then restart from address 0
        go_reset();
        clear_rom();
        rom[0] = 16'h2053;
        p_init(); p_fetch(7'd0); p_dec(); p_lda(8'h05);
        release_rst();
        repeat (4) @(posedge clk);
        #2 chk("ldb_wen_pre", {31'd0, bus.RF_W_en}, 32'd1);
        rst_n = 1'b0;
        #1 chk("ldb_wen_rst", {31'd0, bus.RF_W_en}, 32'd0);
        chk_zero("midrst");
        chk("midrst_q", exp_q.size(), 32'd0);
        p_init(); p_fetch(7'd0); p_dec(); p_lda(8'h05); p_ldb(8'h05, 4'd3);
        p_fetch(7'd1);
        release_rst();
        drain("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang exp finish");
        $fatal(1);
    end

endmodule
